// File: rtl/mem_io_ctrl.sv
// Memory/I-O bus controller: decodes the 9-bit address onto RAM, LED, switches,
// access counters and an error-capture register, returning read data one cycle later.
module mem_io_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LED_W  = 8,
  parameter int SW_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic [7:0]        ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              err
);

  localparam logic [1:0]        CMD_RD = 2'b01;
  localparam logic [1:0]        CMD_WR = 2'b10;
  localparam logic [ADDR_W-1:0] A_LED  = 'h100;
  localparam logic [ADDR_W-1:0] A_SW   = 'h140;
  localparam logic [ADDR_W-1:0] A_RDC  = 'h180;
  localparam logic [ADDR_W-1:0] A_WRC  = 'h181;
  localparam logic [ADDR_W-1:0] A_ERR  = 'h1C0;
  localparam int                CNT_W  = 16;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [ADDR_W+1:0] prev_reg;
  logic [SW_W-1:0]   sw_meta_reg, sw_sync_reg;
  logic [LED_W-1:0]  led_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] err_addr_reg;
  logic [CNT_W-1:0]  rd_cnt_reg, wr_cnt_reg;
  logic              sel_ram_reg;
  logic [DATA_W-1:0] snap_reg;
  logic [DATA_W-1:0] snap_next;

  logic is_rd, is_wr, ts;
  logic hit_ram, hit_led, hit_sw, hit_rdc, hit_wrc, hit_err;
  logic rd_ok, wr_ok, rd_ts, wr_ts, bad_ts;

  assign is_rd   = (mem_cmd == CMD_RD);
  assign is_wr   = (mem_cmd == CMD_WR);
  // A command held unchanged across cycles is one transaction, not many.
  assign ts      = (is_rd || is_wr) && ({mem_cmd, mem_addr} != prev_reg);

  assign hit_ram = (mem_addr[ADDR_W-1:8] == '0);
  assign hit_led = (mem_addr == A_LED);
  assign hit_sw  = (mem_addr == A_SW);
  assign hit_rdc = (mem_addr == A_RDC);
  assign hit_wrc = (mem_addr == A_WRC);
  assign hit_err = (mem_addr == A_ERR);

  assign rd_ok  = hit_ram || hit_led || hit_sw || hit_rdc || hit_wrc || hit_err;
  assign wr_ok  = rd_ok && !hit_sw;
  assign rd_ts  = ts && is_rd && rd_ok;
  assign wr_ts  = ts && is_wr && wr_ok;
  assign bad_ts = ts && ((is_rd && !rd_ok) || (is_wr && !wr_ok));

  assign ram_addr  = mem_addr[7:0];
  assign ram_din   = write_data;
  assign ram_we    = is_wr && hit_ram;
  assign read_data = sel_ram_reg ? ram_dout : snap_reg;
  assign led       = led_reg;
  assign err       = err_reg;

  always_comb begin
    snap_next = '0;
    if (hit_led)      snap_next = DATA_W'(led_reg);
    else if (hit_sw)  snap_next = DATA_W'(sw_sync_reg);
    else if (hit_rdc) snap_next = DATA_W'(rd_cnt_reg);
    else if (hit_wrc) snap_next = DATA_W'(wr_cnt_reg);
    else if (hit_err) snap_next = DATA_W'({err_reg, 6'b0, err_addr_reg});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg     <= '0;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      led_reg      <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      sel_ram_reg  <= 1'b1;
      snap_reg     <= '0;
    end else begin
      prev_reg    <= {mem_cmd, mem_addr};
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;

      if (is_rd) begin
        sel_ram_reg <= hit_ram;
        snap_reg    <= snap_next;
      end

      if (wr_ts && hit_led)
        led_reg <= write_data[LED_W-1:0];

      // Clearing a counter takes priority over the write count it would also receive.
      if (wr_ts && hit_rdc)
        rd_cnt_reg <= '0;
      else if (rd_ts && rd_cnt_reg != CNT_MAX)
        rd_cnt_reg <= rd_cnt_reg + 1'b1;

      if (wr_ts && hit_wrc)
        wr_cnt_reg <= '0;
      else if (wr_ts && wr_cnt_reg != CNT_MAX)
        wr_cnt_reg <= wr_cnt_reg + 1'b1;

      if (wr_ts && hit_err) begin
        err_reg      <= 1'b0;
        err_addr_reg <= '0;
      end else if (bad_ts) begin
        err_reg <= 1'b1;
        if (!err_reg)
          err_addr_reg <= mem_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  mem_io_ctrl dut (
    .clk(clk), .rst(rst), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .read_data(read_data), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout), .sw(sw),
    .led(led), .err(err)
  );

  always #5 clk = ~clk;

  // External synchronous RAM
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    ram_dout = 16'h0000;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        exp_we;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
    logic        exp_err;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(logic [1:0] c, logic [8:0] a, logic [15:0] w, logic we,
                              logic cr, logic [15:0] rd, logic [7:0] l, logic e);
    vec_t v;
    v.cmd = c; v.addr = a; v.wdata = w; v.exp_we = we;
    v.chk_rd = cr; v.exp_rd = rd; v.exp_led = l; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_cmd = 2'b00; mem_addr = 9'h000; write_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
    mem_cmd = c; mem_addr = a; write_data = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sw = 8'h3C;
    do_reset();
    check("reset_led", {8'h00, led}, 16'h0000);
    check("reset_err", {15'h0, err}, 16'h0000);
    check("reset_rd", read_data, 16'h0000);

    //            cmd    addr    wdata    we    chk   exp_rd    led    err
    vecs[0]  = mk(2'b10, 9'h005, 16'h1234, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    vecs[1]  = mk(2'b10, 9'h005, 16'h1234, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    vecs[2]  = mk(2'b10, 9'h005, 16'h1234, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    vecs[3]  = mk(2'b01, 9'h005, 16'h0000, 1'b0, 1'b1, 16'h1234, 8'h00, 1'b0);
    vecs[4]  = mk(2'b01, 9'h180, 16'h0000, 1'b0, 1'b1, 16'h0001, 8'h00, 1'b0);
    vecs[5]  = mk(2'b01, 9'h181, 16'h0000, 1'b0, 1'b1, 16'h0001, 8'h00, 1'b0);
    vecs[6]  = mk(2'b10, 9'h100, 16'h00A5, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b0);
    vecs[7]  = mk(2'b00, 9'h000, 16'h0000, 1'b0, 1'b1, 16'h0001, 8'hA5, 1'b0);
    vecs[8]  = mk(2'b01, 9'h140, 16'h0000, 1'b0, 1'b1, 16'h003C, 8'hA5, 1'b0);
    vecs[9]  = mk(2'b10, 9'h1FF, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b1);
    vecs[10] = mk(2'b10, 9'h140, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b1);
    vecs[11] = mk(2'b01, 9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h81FF, 8'hA5, 1'b1);
    vecs[12] = mk(2'b10, 9'h1C0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b0);
    vecs[13] = mk(2'b01, 9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5, 1'b0);
    vecs[14] = mk(2'b10, 9'h0FF, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 8'hA5, 1'b0);
    vecs[15] = mk(2'b01, 9'h0FF, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 8'hA5, 1'b0);
    vecs[16] = mk(2'b01, 9'h100, 16'h0000, 1'b0, 1'b1, 16'h00A5, 8'hA5, 1'b0);
    vecs[17] = mk(2'b11, 9'h1FF, 16'h0000, 1'b0, 1'b1, 16'h00A5, 8'hA5, 1'b0);
    vecs[18] = mk(2'b11, 9'h005, 16'h0000, 1'b0, 1'b1, 16'h00A5, 8'hA5, 1'b0);
    vecs[19] = mk(2'b01, 9'h180, 16'h0000, 1'b0, 1'b1, 16'h0008, 8'hA5, 1'b0);
    vecs[20] = mk(2'b01, 9'h181, 16'h0000, 1'b0, 1'b1, 16'h0004, 8'hA5, 1'b0);
    vecs[21] = mk(2'b10, 9'h180, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b0);
    vecs[22] = mk(2'b01, 9'h180, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5, 1'b0);
    vecs[23] = mk(2'b01, 9'h101, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5, 1'b1);
    vecs[24] = mk(2'b01, 9'h1C0, 16'h0000, 1'b0, 1'b1, 16'h8101, 8'hA5, 1'b1);
    vecs[25] = mk(2'b10, 9'h181, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b1);
    vecs[26] = mk(2'b01, 9'h181, 16'h0000, 1'b0, 1'b1, 16'h0000, 8'hA5, 1'b1);

    for (int i = 0; i < 27; i++) begin
      mem_cmd = vecs[i].cmd; mem_addr = vecs[i].addr; write_data = vecs[i].wdata;
      #1;
      check($sformatf("v%0d_we", i), {15'h0, ram_we}, {15'h0, vecs[i].exp_we});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_led", i), {8'h00, led}, {8'h00, vecs[i].exp_led});
      check($sformatf("v%0d_err", i), {15'h0, err}, {15'h0, vecs[i].exp_err});
      if (vecs[i].chk_rd)
        check($sformatf("v%0d_rd", i), read_data, vecs[i].exp_rd);
      $display("vec %0d cmd=%b addr=0x%03h wdata=0x%04h -> rd=0x%04h led=0x%02h err=%b",
               i, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, read_data, led, err);
    end

    // Reset during a held LED write, then the same command again counts as new.
    step(2'b10, 9'h100, 16'h00FF);
    step(2'b10, 9'h100, 16'h00FF);
    check("hold_led", {8'h00, led}, 16'h00FF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_led", {8'h00, led}, 16'h0000);
    check("rst_err", {15'h0, err}, 16'h0000);
    rst = 1'b0;
    step(2'b10, 9'h100, 16'h00FF);
    check("post_rst_led", {8'h00, led}, 16'h00FF);
    step(2'b01, 9'h181, 16'h0000);
    check("post_rst_wrcnt", read_data, 16'h0001);
    step(2'b01, 9'h180, 16'h0000);
    check("post_rst_rdcnt", read_data, 16'h0001);
    $display("seq reset-mid-write led=0x%02h rd=0x%04h", led, read_data);

    // Held counter read: first result is pre-increment, held cycles are not recounted.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b01, 9'h180, 16'h0000);
      check($sformatf("held_rd%0d", k), read_data, (k == 0) ? 16'h0000 : 16'h0001);
    end
    step(2'b00, 9'h000, 16'h0000);
    $display("seq held-read rd=0x%04h", read_data);

    // Drive RD_CNT to 0xFFFF with alternating reads, then confirm it saturates.
    do_reset();
    for (int i = 0; i < 65535; i++)
      step(2'b01, (i % 2 == 1) ? 9'h001 : 9'h000, 16'h0000);
    step(2'b01, 9'h180, 16'h0000);
    check("sat_rd_first", read_data, 16'hFFFF);
    step(2'b01, 9'h000, 16'h0000);
    step(2'b01, 9'h180, 16'h0000);
    check("sat_rd_hold", read_data, 16'hFFFF);
    step(2'b00, 9'h000, 16'h0000);
    $display("seq saturate rd=0x%04h", read_data);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
